// File: rtl/seg_scan_monitor_if.sv
// Traffic display pins plus the monitor's decoded view of them.
// The scan driver owns the pins; the monitor owns the results.
interface seg_scan_monitor_if;
  logic [3:0]  sel;
  logic [7:0]  seg_led;
  logic [5:0]  led;
  logic [15:0] digits;
  logic [6:0]  ew_cnt;
  logic [6:0]  ns_cnt;
  logic        frame_valid;
  logic        frame_changed;
  logic        scan_err;
  logic        light_err;

  modport master (
    output sel, seg_led, led,
    input  digits, ew_cnt, ns_cnt,
    input  frame_valid, frame_changed,
    input  scan_err, light_err
  );

  modport slave (
    input  sel, seg_led, led,
    output digits, ew_cnt, ns_cnt,
    output frame_valid, frame_changed,
    output scan_err, light_err
  );
endinterface

// File: rtl/seg_scan_monitor.sv
// Passive decoder of the multiplexed 4-digit scan and LED pattern.
// Rebuilds settled frames, converts them to counts, flags bad lights.
module seg_scan_monitor #(
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 50000
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  seg_scan_monitor_if.slave pins
);

  localparam logic [7:0]  SET_M1 = 8'(SETTLE - 1);
  localparam logic [15:0] TO_M1  = 16'(TIMEOUT - 1);
  localparam logic [5:0]  ALL_RED = 6'b100100;

  logic [3:0]  sel_q;
  logic [6:0]  seg_q;
  logic [5:0]  led_q;
  logic [10:0] key_q;
  logic [7:0]  dwell_q;
  logic [7:0]  dwell_d;
  logic [3:0]  mask_q;
  logic [3:0]  mask_d;
  logic [15:0] slot_q;
  logic [15:0] idle_q;
  logic [15:0] digits_q;
  logic [6:0]  ew_q;
  logic [6:0]  ns_q;
  logic        fv_q;
  logic        fc_q;
  logic        serr_q;
  logic        lerr_q;

  logic        sel_ok;
  logic [1:0]  idx;
  logic        cap;
  logic        publish;
  logic        tmo;
  logic        light_bad;
  logic        unused_dp;

  assign unused_dp = pins.seg_led[7];

  function automatic logic [3:0] dec(
    input logic [6:0] s
  );
    case (s)
      7'h40:   return 4'd0;
      7'h79:   return 4'd1;
      7'h24:   return 4'd2;
      7'h30:   return 4'd3;
      7'h19:   return 4'd4;
      7'h12:   return 4'd5;
      7'h02:   return 4'd6;
      7'h78:   return 4'd7;
      7'h00:   return 4'd8;
      7'h10:   return 4'd9;
      7'h7F:   return 4'hF;
      default: return 4'hE;
    endcase
  endfunction

  // blank tens reads as zero; blank units or bad glyph saturates
  function automatic logic [6:0] to_cnt(
    input logic [3:0] t,
    input logic [3:0] u
  );
    logic [6:0] tv;
    tv = (t == 4'hF) ? 7'd0 : {3'd0, t};
    if (t == 4'hE || u == 4'hE || u == 4'hF)
      return 7'd127;
    return (tv << 3) + (tv << 1) + {3'd0, u};
  endfunction

  function automatic logic onehot3(
    input logic [2:0] v
  );
    return v == 3'b001 || v == 3'b010 || v == 3'b100;
  endfunction

  always_comb begin
    sel_ok = 1'b1;
    idx    = 2'd0;
    case (sel_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: sel_ok = 1'b0;
    endcase
  end

  always_comb begin
    dwell_d = dwell_q;
    if ({sel_q, seg_q} != key_q)
      dwell_d = 8'd0;
    else if (dwell_q != 8'hFF)
      dwell_d = dwell_q + 8'd1;
  end

  assign cap     = sel_ok && (dwell_d == SET_M1);
  assign publish = (mask_q == 4'hF);
  assign tmo     = (idle_q == TO_M1) && !cap;

  always_comb begin
    mask_d = mask_q;
    if (publish || tmo)
      mask_d = 4'h0;
    if (cap)
      mask_d[idx] = 1'b1;
  end

  assign light_bad = !onehot3(led_q[5:3])
                  || !onehot3(led_q[2:0])
                  || (!led_q[5] && !led_q[2]);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel_q    <= 4'hF;
      seg_q    <= 7'h7F;
      led_q    <= ALL_RED;
      key_q    <= {4'hF, 7'h7F};
      dwell_q  <= 8'd0;
      mask_q   <= 4'h0;
      slot_q   <= 16'hFFFF;
      idle_q   <= 16'd0;
      digits_q <= 16'hFFFF;
      ew_q     <= 7'd0;
      ns_q     <= 7'd0;
      fv_q     <= 1'b0;
      fc_q     <= 1'b0;
      serr_q   <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      sel_q   <= pins.sel;
      seg_q   <= pins.seg_led[6:0];
      led_q   <= pins.led;
      key_q   <= {sel_q, seg_q};
      dwell_q <= dwell_d;
      mask_q  <= mask_d;
      if (cap)
        slot_q[{idx, 2'b00} +: 4] <= dec(seg_q);
      if (cap)
        idle_q <= 16'd0;
      else if (idle_q != TO_M1)
        idle_q <= idle_q + 16'd1;
      fv_q <= publish;
      fc_q <= publish && (slot_q != digits_q);
      if (publish) begin
        digits_q <= slot_q;
        ew_q     <= to_cnt(slot_q[15:12], slot_q[11:8]);
        ns_q     <= to_cnt(slot_q[7:4], slot_q[3:0]);
      end
      if (publish)
        serr_q <= 1'b0;
      else if (tmo)
        serr_q <= 1'b1;
      lerr_q <= light_bad;
    end
  end

  assign pins.digits        = digits_q;
  assign pins.ew_cnt        = ew_q;
  assign pins.ns_cnt        = ns_q;
  assign pins.frame_valid   = fv_q;
  assign pins.frame_changed = fc_q;
  assign pins.scan_err      = serr_q;
  assign pins.light_err     = lerr_q;

endmodule

// File: tb/tb_seg_scan_monitor.sv
// Bench for seg_scan_monitor: directed scans plus random dwells
// compared every cycle against a dwell-level reference model.
module tb_seg_scan_monitor;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 50000;
  localparam logic [5:0] RED2 = 6'b100100;

  typedef struct {
    int         at;
    int         idx;
    logic [3:0] nib;
  } cap_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_monitor_if bus();

  seg_scan_monitor #(
    .SETTLE (SETTLE),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .pins     (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24,
    7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [5:0] legal [5] = '{6'b100001, 6'b100010,
    6'b001100, 6'b010100, 6'b100100};

  cap_t        capq[$];
  int          pub_at = -1;
  logic [15:0] pub_val;
  logic [3:0]  m_slot [4];
  logic [3:0]  m_mask;
  logic [15:0] m_digits;
  int          m_ew, m_ns;
  bit          m_err, m_fv, m_fc;
  int          m_last;
  bit          in_rst;
  logic [5:0]  led_h1 = RED2;
  logic [5:0]  led_h2 = RED2;
  logic [10:0] cur_key;
  int          cur_start;
  bit          tent;

  int   fv_n = 0;
  int   first_fv = -1;
  logic fc1 = 1'bx;
  logic fc2 = 1'bx;

  function automatic logic [3:0] mnib(logic [6:0] s);
    for (int i = 0; i < 10; i++)
      if (s == seg_tab[i]) return 4'(i);
    if (s == 7'h7F) return 4'hF;
    return 4'hE;
  endfunction

  function automatic int mcnt(logic [3:0] t, logic [3:0] u);
    if (t == 4'hE || u == 4'hE || u == 4'hF) return 127;
    return ((t == 4'hF) ? 0 : int'(t)) * 10 + int'(u);
  endfunction

  function automatic bit lbad(logic [5:0] l);
    return $countones(l[5:3]) != 1 || $countones(l[2:0]) != 1
        || (!l[5] && !l[2]);
  endfunction

  function automatic int sidx(logic [3:0] s);
    case (s)
      4'hE: return 0;
      4'hD: return 1;
      4'hB: return 2;
      4'h7: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] o,
                     input logic [15:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d",
             tag, o, e, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    led_h2 = led_h1;
    led_h1 = bus.led;
    m_fv = 0;
    m_fc = 0;
    if (in_rst) begin
      m_last = cyc;
      led_h1 = RED2;
      led_h2 = RED2;
    end else begin
      if (pub_at == cyc) begin
        m_fv = 1;
        m_fc = (pub_val != m_digits);
        m_digits = pub_val;
        m_ew = mcnt(pub_val[15:12], pub_val[11:8]);
        m_ns = mcnt(pub_val[7:4], pub_val[3:0]);
        m_err = 0;
        m_mask = 4'h0;
      end
      while (capq.size() > 0 && capq[0].at == cyc) begin
        m_slot[capq[0].idx] = capq[0].nib;
        m_mask[capq[0].idx] = 1'b1;
        m_last = cyc;
        void'(capq.pop_front());
      end
      if (m_mask == 4'hF) begin
        pub_at = cyc + 1;
        pub_val = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
      end
      if (!m_fv && cyc - m_last >= TIMEOUT) begin
        m_err = 1;
        m_mask = 4'h0;
      end
    end
    chk("frame_valid", 16'(bus.frame_valid), 16'(m_fv));
    chk("frame_changed", 16'(bus.frame_changed), 16'(m_fc));
    chk("digits", bus.digits, m_digits);
    chk("ew_cnt", 16'(bus.ew_cnt), 16'(m_ew));
    chk("ns_cnt", 16'(bus.ns_cnt), 16'(m_ns));
    chk("scan_err", 16'(bus.scan_err), 16'(m_err));
    chk("light_err", 16'(bus.light_err), 16'(lbad(led_h2)));
    if (bus.frame_valid === 1'b1) begin
      fv_n++;
      if (fv_n == 1) begin
        first_fv = cyc;
        fc1 = bus.frame_changed;
      end
      if (fv_n == 2) fc2 = bus.frame_changed;
    end
  endtask

  task automatic drive(input logic [3:0] s, input logic [7:0] g,
                       input logic [5:0] l);
    logic [10:0] k;
    cap_t e;
    bus.sel = s;
    bus.seg_led = g;
    bus.led = l;
    k = {s, g[6:0]};
    if (k != cur_key) begin
      if (tent && cyc - cur_start < SETTLE) void'(capq.pop_back());
      cur_key = k;
      cur_start = cyc;
      tent = 0;
      if (sidx(s) >= 0) begin
        e.at = cyc + SETTLE + 1;
        e.idx = sidx(s);
        e.nib = mnib(g[6:0]);
        capq.push_back(e);
        tent = 1;
      end
    end
  endtask

  task automatic show(input logic [3:0] s, input logic [7:0] g,
                      input logic [5:0] l, input int n);
    drive(s, g, l);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_rst = 1;
    m_digits = 16'hFFFF;
    m_ew = 0;
    m_ns = 0;
    m_err = 0;
    m_mask = 4'h0;
    capq.delete();
    pub_at = -1;
    tent = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    in_rst = 0;
    cur_key = {4'hF, 7'h7F};
    cur_start = cyc;
    drive(bus.sel, bus.seg_led, bus.led);
  endtask

  initial begin
    int ns_start, fvb;
    logic [3:0] s;
    logic [6:0] g7;
    logic [5:0] l;
    bus.sel = 4'hF;
    bus.seg_led = 8'hFF;
    bus.led = RED2;
    for (int i = 0; i < 4; i++) m_slot[i] = 4'hF;
    do_reset();
    chk("rst_digits", bus.digits, 16'hFFFF);

    for (int f = 0; f < 2; f++) begin
      show(4'h7, 8'hF9, legal[0], 1000);
      show(4'hB, 8'h92, legal[1], 1000);
      show(4'hD, 8'hC0, legal[2], 1000);
      if (f == 0) ns_start = cyc;
      show(4'hE, 8'h90, legal[3], 1000);
    end
    chk("f1_digits", bus.digits, 16'h1509);
    chk("f1_ew", 16'(bus.ew_cnt), 16'd15);
    chk("f1_ns", 16'(bus.ns_cnt), 16'd9);
    chk("f1_count", 16'(fv_n), 16'd2);
    chk("f1_latency", 16'(first_fv - ns_start), 16'(SETTLE + 2));
    chk("f1_changed", 16'(fc1), 16'd1);
    chk("f2_changed", 16'(fc2), 16'd0);

    show(4'h7, 8'hFF, RED2, 40);
    show(4'hB, 8'hF8, RED2, 40);
    show(4'hD, 8'hC0, RED2, 40);
    show(4'hE, 8'hC0, RED2, 40);
    chk("blank_digits", bus.digits, 16'hF700);
    chk("blank_ew", 16'(bus.ew_cnt), 16'd7);

    show(4'h7, 8'hF9, RED2, 40);
    show(4'hB, 8'hA4, RED2, 40);
    show(4'hD, 8'hB0, RED2, 40);
    show(4'hE, 8'h55, RED2, 40);
    chk("bad_digits", bus.digits, 16'h123E);
    chk("bad_ns", 16'(bus.ns_cnt), 16'd127);

    fvb = fv_n;
    show(4'h7, 8'hA4, RED2, 40);
    show(4'hD, 8'h80, RED2, 8);
    show(4'hB, 8'hB0, RED2, 40);
    show(4'hE, 8'h80, RED2, 8);
    show(4'hD, 8'h99, RED2, 40);
    show(4'h7, 8'h80, RED2, 8);
    show(4'hE, 8'h82, RED2, 40);
    chk("glitch_digits", bus.digits, 16'h2346);
    chk("glitch_frames", 16'(fv_n - fvb), 16'd1);

    show(4'hF, 8'hFF, 6'b001001, 2);
    chk("both_green", 16'(bus.light_err), 16'd1);
    show(4'hF, 8'hFF, 6'b100100, 2);
    chk("all_red", 16'(bus.light_err), 16'd0);

    show(4'hF, 8'hFF, RED2, TIMEOUT + 5);
    chk("timeout_err", 16'(bus.scan_err), 16'd1);
    fvb = fv_n;
    show(4'h7, 8'hC0, RED2, 40);
    show(4'hB, 8'hF9, RED2, 40);
    show(4'hD, 8'hA4, RED2, 40);
    show(4'hE, 8'hB0, RED2, 40);
    chk("recover_err", 16'(bus.scan_err), 16'd0);
    chk("recover_frame", 16'(fv_n - fvb), 16'd1);

    show(4'h7, 8'h99, RED2, 40);
    show(4'hB, 8'h92, RED2, 40);
    drive(4'hF, 8'hFF, RED2);
    do_reset();
    chk("mid_rst_digits", bus.digits, 16'hFFFF);
    chk("mid_rst_ew", 16'(bus.ew_cnt), 16'd0);
    fvb = fv_n;
    show(4'hD, 8'hF8, RED2, 40);
    show(4'hE, 8'h80, RED2, 40);
    show(4'hF, 8'hFF, RED2, 10);
    chk("mid_rst_partial", 16'(fv_n - fvb), 16'd0);
    show(4'h7, 8'h99, RED2, 40);
    show(4'hB, 8'h92, RED2, 40);
    show(4'hF, 8'hFF, RED2, 10);
    chk("mid_rst_full", 16'(fv_n - fvb), 16'd1);
    chk("mid_rst_value", bus.digits, 16'h4578);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: s = 4'hE;
        1: s = 4'hD;
        2: s = 4'hB;
        3: s = 4'h7;
        4: s = 4'hF;
        default: s = 4'($urandom);
      endcase
      case ($urandom_range(0, 9))
        7: g7 = 7'h7F;
        8, 9: g7 = 7'($urandom);
        default: g7 = seg_tab[$urandom_range(0, 9)];
      endcase
      if ($urandom_range(0, 3) == 0) l = 6'($urandom);
      else l = legal[$urandom_range(0, 4)];
      show(s, {1'($urandom), g7}, l, $urandom_range(3, 40));
    end
    show(4'hF, 8'hFF, RED2, 30);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
